// File: rtl/approx_mult_pkg.sv
// Shared types and default sizing for the approximate-multiplier product accumulator.
package approx_mult_pkg;

  localparam int DEF_ACC_W   = 24;
  localparam int DEF_MAX_LEN = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accum_8x8_if.sv
// Beat-in / result-out handshake bundle for prod_accum_8x8.
interface prod_accum_8x8_if
  import approx_mult_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_LEN = DEF_MAX_LEN
);
  localparam int CNT_W = $clog2(MAX_LEN) + 1;

  logic             in_valid;
  logic [15:0]      in_prod;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

endinterface

// File: rtl/prod_accum_8x8_sat_add.sv
// Combinational accumulator adder; PROD_ACCUM_SAT_EN selects clamp-to-max with overflow
// flag, otherwise the sum wraps and the flag is held low.
module sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

`ifdef PROD_ACCUM_SAT_EN
  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum  = w_full[W] ? '1 : w_full[W-1:0];
  assign o_ovf  = w_full[W];
`else
  assign o_sum  = i_a + i_b;
  assign o_ovf  = 1'b0;
`endif

endmodule

// File: rtl/prod_accum_8x8.sv
// Accumulates a vector of 16-bit multiplier products and hands out sum/count/overflow.
// Overflow handling is selected by PROD_ACCUM_SAT_EN (see sat_add).
module prod_accum_8x8
  import approx_mult_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic            clk,
  input  logic            rst,
  prod_accum_8x8_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LEN) + 1;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_ovf;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_take;
  logic             w_first;
  logic             w_close;
  logic             w_add_ovf;
  logic             w_ovf_next;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_prod;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_in_ready = (r_state != ST_DONE);
  assign w_take     = bus.in_valid && w_in_ready;
  assign w_first    = (r_state == ST_IDLE);

  // The first beat of a vector adds onto zero, so load and accumulate share one adder.
  assign w_base     = w_first ? '0 : r_acc;
  assign w_prod     = ACC_W'(bus.in_prod);
  assign w_cnt_next = w_first ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_ovf_next = (!w_first && r_ovf) || w_add_ovf;
  assign w_close    = bus.in_last || (w_cnt_next == CNT_W'(MAX_LEN));

  sat_add #(.W(ACC_W)) u_sat_add (
    .i_a   (w_base),
    .i_b   (w_prod),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACC: begin
          if (w_take) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
            if (w_close) begin
              r_out_sum   <= w_sum;
              r_out_cnt   <= w_cnt_next;
              r_out_ovf   <= w_ovf_next;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_ACC;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_prod_accum_8x8.sv
// Bench for prod_accum_8x8: three instances (default, MAX_LEN=4, ACC_W=17) against a vector-level model.
module tb_prod_accum_8x8;

  typedef struct {
    int     dut;
    longint sum;
    int     cnt;
    bit     ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iv   [3];
  logic        il   [3];
  logic        ordy [3];
  logic [15:0] ip   [3];
  logic        rdy  [3];
  logic        ov   [3];
  logic        oovf [3];
  logic [31:0] osum [3];
  logic [15:0] ocnt [3];

  int checks   = 0;
  int failures = 0;

  res_t   exp_q[$];
  res_t   obs_q[$];
  longint m_sum [3];
  int     m_cnt [3];
  int     acc_w   [3] = '{24, 24, 17};
  int     max_len [3] = '{256, 4, 256};

  always #5 clk = ~clk;

  prod_accum_8x8_if #(.ACC_W(24), .MAX_LEN(256)) if0 ();
  prod_accum_8x8_if #(.ACC_W(24), .MAX_LEN(4))   if1 ();
  prod_accum_8x8_if #(.ACC_W(17), .MAX_LEN(256)) if2 ();

  prod_accum_8x8 #(.ACC_W(24), .MAX_LEN(256)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  prod_accum_8x8 #(.ACC_W(24), .MAX_LEN(4))   dut1 (.clk(clk), .rst(rst), .bus(if1));
  prod_accum_8x8 #(.ACC_W(17), .MAX_LEN(256)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.in_valid  = iv[0];
  assign if0.in_prod   = ip[0];
  assign if0.in_last   = il[0];
  assign if0.out_ready = ordy[0];
  assign rdy[0]  = if0.in_ready;
  assign ov[0]   = if0.out_valid;
  assign osum[0] = 32'(if0.out_sum);
  assign ocnt[0] = 16'(if0.out_cnt);
  assign oovf[0] = if0.out_ovf;

  assign if1.in_valid  = iv[1];
  assign if1.in_prod   = ip[1];
  assign if1.in_last   = il[1];
  assign if1.out_ready = ordy[1];
  assign rdy[1]  = if1.in_ready;
  assign ov[1]   = if1.out_valid;
  assign osum[1] = 32'(if1.out_sum);
  assign ocnt[1] = 16'(if1.out_cnt);
  assign oovf[1] = if1.out_ovf;

  assign if2.in_valid  = iv[2];
  assign if2.in_prod   = ip[2];
  assign if2.in_last   = il[2];
  assign if2.out_ready = ordy[2];
  assign rdy[2]  = if2.in_ready;
  assign ov[2]   = if2.out_valid;
  assign osum[2] = 32'(if2.out_sum);
  assign ocnt[2] = 16'(if2.out_cnt);
  assign oovf[2] = if2.out_ovf;

  // Record every completed output handshake; inputs change just after posedge, so negedge is stable.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ov[d] && ordy[d]) begin
        res_t r;
        r.dut = d;
        r.sum = longint'(osum[d]);
        r.cnt = int'(ocnt[d]);
        r.ovf = oovf[d];
        obs_q.push_back(r);
      end
    end
  end

  // Vector result from the running totals: clamp or wrap the plain integer sum.
  function automatic res_t mk_res(input int d);
    res_t   r;
    longint mx;
    mx    = (longint'(1) << acc_w[d]) - 1;
    r.dut = d;
    r.cnt = m_cnt[d];
`ifdef PROD_ACCUM_SAT_EN
    r.sum = (m_sum[d] > mx) ? mx : m_sum[d];
    r.ovf = (m_sum[d] > mx);
`else
    r.sum = m_sum[d] & mx;
    r.ovf = 1'b0;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      m_sum[d] = 0;
      m_cnt[d] = 0;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic beat(input int d, input logic [15:0] p, input logic last);
    bit got;
    got   = 1'b0;
    iv[d] = 1'b1;
    ip[d] = p;
    il[d] = last;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (rdy[d]) got = 1'b1;
      tick();
    end
    iv[d] = 1'b0;
    il[d] = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout dut=%0d in_ready stayed 0, required 1", d);
    end else begin
      m_sum[d] += longint'(p);
      m_cnt[d]++;
      if (last || m_cnt[d] == max_len[d]) begin
        exp_q.push_back(mk_res(d));
        m_sum[d] = 0;
        m_cnt[d] = 0;
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || osum[d] !== 32'd0 || ocnt[d] !== 16'd0 || oovf[d] !== 1'b0 || rdy[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset_state dut=%0d got v=%b s=%0d c=%0d o=%b r=%b, required 0 0 0 0 1",
                 d, ov[d], osum[d], ocnt[d], oovf[d], rdy[d]);
      end
    end
    ordy[0] = 1'b0;
    beat(0, 16'd5, 1'b1);
    checks++;
    if (ov[0] !== 1'b1) begin
      failures++;
      $display("FAIL pending_before_reset got %b, required 1", ov[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || osum[0] !== 32'd0 || ocnt[0] !== 16'd0 || rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got v=%b s=%0d c=%0d r=%b, required 0 0 0 1", ov[0], osum[0], ocnt[0], rdy[0]);
    end
    tick();
    ordy[0] = 1'b1;
    rst = 1'b0;
    idle(2);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL reset_drops_pending got %0d handshakes, required 0", obs_q.size());
    end
    clear_model();
  endtask

  task automatic test_basic();
    clear_model();
    ordy[0] = 1'b1;
    beat(0, 16'd100, 1'b0);
    beat(0, 16'd200, 1'b0);
    beat(0, 16'd300, 1'b1);
    checks++;
    if (ov[0] !== 1'b1 || osum[0] !== 32'd600 || ocnt[0] !== 16'd3 || oovf[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got v=%b s=%0d c=%0d o=%b r=%b, required 1 600 3 0 0",
               ov[0], osum[0], ocnt[0], oovf[0], rdy[0]);
    end
    tick();
    checks++;
    if (ov[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_release got v=%b r=%b, required 0 1", ov[0], rdy[0]);
    end
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL basic_count got obs=%0d exp=%0d, required 1 1", obs_q.size(), exp_q.size());
    end else if (obs_q[0].sum != exp_q[0].sum || obs_q[0].cnt != exp_q[0].cnt) begin
      failures++;
      $display("FAIL basic_model got %0d/%0d, required %0d/%0d", obs_q[0].sum, obs_q[0].cnt, exp_q[0].sum, exp_q[0].cnt);
    end
  endtask

  task automatic test_backpressure();
    clear_model();
    ordy[0] = 1'b0;
    beat(0, 16'd100, 1'b0);
    beat(0, 16'd200, 1'b0);
    beat(0, 16'd300, 1'b1);
    iv[0] = 1'b1;
    ip[0] = 16'd999;
    il[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov[0] !== 1'b1 || osum[0] !== 32'd600 || ocnt[0] !== 16'd3 || rdy[0] !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got v=%b s=%0d c=%0d r=%b, required 1 600 3 0",
                 i, ov[0], osum[0], ocnt[0], rdy[0]);
      end
      tick();
    end
    iv[0]   = 1'b0;
    il[0]   = 1'b0;
    ordy[0] = 1'b1;
    tick();
    checks++;
    if (ov[0] !== 1'b0 || rdy[0] !== 1'b1 || obs_q.size() != 1) begin
      failures++;
      $display("FAIL stall_release got v=%b r=%b hs=%0d, required 0 1 1", ov[0], rdy[0], obs_q.size());
    end
    idle(2);
    checks++;
    if (obs_q.size() != 1 || ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL stall_ignored_beat got hs=%0d v=%b, required 1 0", obs_q.size(), ov[0]);
    end
  endtask

  task automatic test_maxlen();
    clear_model();
    ordy[1] = 1'b1;
    for (int i = 0; i < 6; i++) beat(1, 16'd1000, (i == 5));
    idle(3);
    checks++;
    if (obs_q.size() != 2) begin
      failures++;
      $display("FAIL maxlen_count got %0d, required 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].sum != 4000 || obs_q[0].cnt != 4 || obs_q[0].ovf != 1'b0) begin
        failures++;
        $display("FAIL maxlen_first got %0d/%0d/%0b, required 4000/4/0", obs_q[0].sum, obs_q[0].cnt, obs_q[0].ovf);
      end
      checks++;
      if (obs_q[1].sum != 2000 || obs_q[1].cnt != 2) begin
        failures++;
        $display("FAIL maxlen_second got %0d/%0d, required 2000/2", obs_q[1].sum, obs_q[1].cnt);
      end
    end
  endtask

  task automatic test_sat();
    longint esum;
    bit     eovf;
`ifdef PROD_ACCUM_SAT_EN
    esum = 131071;
    eovf = 1'b1;
`else
    esum = 65533;
    eovf = 1'b0;
`endif
    clear_model();
    ordy[2] = 1'b1;
    for (int i = 0; i < 3; i++) beat(2, 16'hFFFF, (i == 2));
    idle(2);
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL sat_count got %0d, required 1", obs_q.size());
    end else if (obs_q[0].sum != esum || obs_q[0].ovf != eovf || obs_q[0].cnt != 3) begin
      failures++;
      $display("FAIL sat_result got %0d/%0b/%0d, required %0d/%0b/3", obs_q[0].sum, obs_q[0].ovf, obs_q[0].cnt, esum, eovf);
    end
  endtask

  task automatic test_reset_mid();
    clear_model();
    ordy[0] = 1'b1;
    beat(0, 16'd500, 1'b0);
    beat(0, 16'd500, 1'b0);
    pulse_reset();
    beat(0, 16'd7, 1'b0);
    beat(0, 16'd8, 1'b1);
    idle(2);
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL reset_mid_count got %0d, required 1", obs_q.size());
    end else if (obs_q[0].sum != 15 || obs_q[0].cnt != 2) begin
      failures++;
      $display("FAIL reset_mid_result got %0d/%0d, required 15/2", obs_q[0].sum, obs_q[0].cnt);
    end
  endtask

  task automatic test_single_gap();
    clear_model();
    ordy[0] = 1'b1;
    for (int v = 0; v < 3; v++) begin
      beat(0, 16'd42, 1'b1);
      checks++;
      if (ov[0] !== 1'b1 || osum[0] !== 32'd42 || ocnt[0] !== 16'd1) begin
        failures++;
        $display("FAIL single_result vec=%0d got v=%b s=%0d c=%0d, required 1 42 1", v, ov[0], osum[0], ocnt[0]);
      end
      for (int g = 0; g < 3; g++) begin
        tick();
        checks++;
        if (ov[0] !== 1'b0) begin
          failures++;
          $display("FAIL gap_spurious vec=%0d gap=%0d got %b, required 0", v, g, ov[0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 3) begin
      failures++;
      $display("FAIL single_count got %0d, required 3", obs_q.size());
    end
  endtask

  task automatic test_random();
    bit done;
    pulse_reset();
    for (int d = 0; d < 3; d++) begin
      done = 1'b0;
      fork
        begin
          if (d == 0) begin
            for (int i = 0; i < 300; i++) beat(0, 16'($urandom), (i == 299));
          end
          for (int v = 0; v < 25; v++) begin
            int len;
            len = int'($urandom_range((d == 1) ? 7 : 10, 1));
            for (int b = 0; b < len; b++) begin
              beat(d, 16'($urandom), (b == len - 1) && ($urandom_range(3, 0) != 0));
              if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
            end
          end
          beat(d, 16'($urandom), 1'b1);
          done = 1'b1;
        end
        begin
          while (!done) begin
            ordy[d] = 1'($urandom_range(1, 0));
            tick();
          end
        end
      join
      ordy[d] = 1'b1;
      idle(4);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_count got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].dut != exp_q[i].dut || obs_q[i].sum != exp_q[i].sum ||
          obs_q[i].cnt != exp_q[i].cnt || obs_q[i].ovf != exp_q[i].ovf) begin
        failures++;
        $display("FAIL random_result idx=%0d got d%0d %0d/%0d/%0b, required d%0d %0d/%0d/%0b", i,
                 obs_q[i].dut, obs_q[i].sum, obs_q[i].cnt, obs_q[i].ovf,
                 exp_q[i].dut, exp_q[i].sum, exp_q[i].cnt, exp_q[i].ovf);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      il[d]   = 1'b0;
      ip[d]   = '0;
      ordy[d] = 1'b1;
    end
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    clear_model();
    idle(1);
    test_reset();
    test_basic();
    test_backpressure();
    test_maxlen();
    test_sat();
    test_reset_mid();
    test_single_gap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prod_accum_8x8.md
PROD_ACCUM_8X8 -- requirements
Module: prod_accum_8x8

Interface
REQ-001 Parameter: ACC_W, 24, accumulator and result width in bits; legal range 16..32.
REQ-002 Parameter: MAX_LEN, 256, maximum beats per vector; a vector is force-closed when its count reaches this value.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  a 16-bit product from the 8x8 approximate multiplier is presented.
REQ-006 Port: in_prod  input  16  unsigned product R from the multiplier.
REQ-007 Port: in_last  input  1  the current beat closes the vector.
REQ-008 Port: in_ready  output  1  the block accepts a beat this cycle.
REQ-009 Port: out_valid  output  1  the result registers hold an unconsumed result.
REQ-010 Port: out_ready  input  1  the downstream stage accepts the result.
REQ-011 Port: out_sum  output  ACC_W  accumulated sum of the vector.
REQ-012 Port: out_cnt  output  clog2(MAX_LEN)+1  number of beats in the vector.
REQ-013 Port: out_ovf  output  1  the accumulator overflowed during the vector.

Function
REQ-014 A beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-015 The FSM SHALL have three states:
- IDLE: no beat of the current vector yet.
- ACC: mid-vector.
- DONE: result held.
REQ-016 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-017 In IDLE, an accepted beat SHALL load acc=in_prod (zero-extended) and cnt=1, and SHALL go to ACC unless the beat closes the vector.
REQ-018 In ACC, an accepted beat SHALL set acc=acc+in_prod and cnt=cnt+1.
REQ-019 A beat SHALL close the vector when in_last=1 or the new cnt equals MAX_LEN; both conditions together close it once.
REQ-020 On a closing beat, the next edge SHALL load out_sum, out_cnt and out_ovf from the updated values, assert out_valid, and enter DONE (latency: 1 cycle).
REQ-021 In DONE, out_valid=1 and out_ready=1 SHALL return the FSM to IDLE on that edge and clear out_valid.
REQ-022 In DONE, the outputs SHALL stay stable while out_ready=0.
REQ-023 in_valid=0 in IDLE or ACC SHALL leave all state unchanged; the block tolerates arbitrary gaps between beats.
REQ-024 in_prod, in_last and in_valid SHALL be ignored whenever in_ready=0.
REQ-025 out_sum, out_cnt and out_ovf SHALL be meaningful only while out_valid=1, and SHALL hold their last values otherwise.

Reset
REQ-026 On rst=1, the block SHALL asynchronously enter IDLE with acc, cnt, ovf, out_sum, out_cnt, out_ovf and out_valid all 0.
REQ-027 Asserting reset mid-vector or in DONE SHALL discard the partial or pending result with no output handshake.
REQ-028 After reset release, the first accepted beat SHALL start a new vector.

Configuration
REQ-029 Macro PROD_ACCUM_SAT_EN SHALL select the overflow handling.
REQ-030 When PROD_ACCUM_SAT_EN is defined, an addition exceeding 2^ACC_W-1 SHALL clamp acc to 2^ACC_W-1 and set a sticky ovf bit for the rest of the vector.
REQ-031 When PROD_ACCUM_SAT_EN is undefined, acc SHALL wrap modulo 2^ACC_W and out_ovf SHALL be tied to 0.

Structure
REQ-032 The FSM state enum and the default ACC_W and MAX_LEN constants SHALL live in the shared package approx_mult_pkg.
REQ-033 The adder and clamp SHALL be one combinational sub-module, sat_add, of width ACC_W, whose saturation logic is gated by PROD_ACCUM_SAT_EN.
REQ-034 All registers SHALL live in prod_accum_8x8.
REQ-035 prod_accum_8x8 SHALL NOT instantiate the multiplier; in_prod connects to its R output at the top level.

Verification
REQ-036 Beats 100, 200, 300 with in_last on the third, out_ready=1 -> one cycle later out_valid=1, out_sum=600, out_cnt=3, out_ovf=0.
REQ-037 Same vector with out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout; when out_ready rises, the handshake occurs, and IDLE with in_ready=1 follows on the next cycle.
REQ-038 MAX_LEN=4, six beats of 1000 with no in_last -> first result out_sum=4000, out_cnt=4; after handshake, the remaining beats start a new vector (out_cnt=2 once in_last is given).
REQ-039 ACC_W=17 with PROD_ACCUM_SAT_EN, three beats of 65535 -> out_sum=131071, out_ovf=1; without the macro -> out_sum=65533, out_ovf=0.
REQ-040 rst pulsed after two beats of 500, then beats 7 and 8 with in_last -> out_sum=15, out_cnt=2.
REQ-041 Single beat 42 with in_last, plus in_valid gaps of 3 cycles between vectors -> out_sum=42, out_cnt=1, with no spurious out_valid.
